exec_controller: RTL and testbench

//  Sequences the CPU core. Turns the front-panel next / run / speedRun / edit / send controls into a single-cycle CPU step enable and ROM program-write strobes.

---
 rtl/exec_controller.sv | 141 ++++++++++++++
 tb/tb_exec_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// exec_controller: front-panel sequencer for the CPU core.
// Turns next/run/speedRun/edit/send into a one-cycle CPU step strobe,
// a CPU hold, a PC clear on leaving programming mode, and ROM write strobes.
module exec_controller #(
  parameter int RUN_DIV  = 1000000,
  parameter int FAST_DIV = 1000,
  parameter int ADDR_W   = 8,
  parameter int CODE_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_next,
  input  logic              i_run,
  input  logic              i_speedRun,
  input  logic              i_edit,
  input  logic [ADDR_W-1:0] i_line,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_send,
  input  logic              i_halt,
  output logic              o_step_en,
  output logic              o_cpu_hold,
  output logic              o_pc_clear,
  output logic              o_rom_we,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [CODE_W-1:0] o_rom_wdata,
  output logic [2:0]        o_mode,
  output logic [7:0]        o_load_count
);

  localparam int CW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FAST = 3'd2,
    EDIT = 3'd3,
    HALT = 3'd4
  } mode_t;

  mode_t             r_mode;
  logic [CW-1:0]     r_cnt;
  logic              r_next_q;
  logic              r_send_q;
  logic              r_step_en;
  logic              r_cpu_hold;
  logic              r_pc_clear;
  logic              r_rom_we;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [CODE_W-1:0] r_rom_wdata;
  logic [7:0]        r_load_count;

  mode_t             w_nmode;
  logic              w_chg;
  logic              w_next_rise;
  logic              w_send_rise;
  logic              w_timed;
  logic [CW-1:0]     w_div_m1;
  logic [7:0]        w_lc_base;

  assign w_next_rise = i_next & ~r_next_q;
  assign w_send_rise = i_send & ~r_send_q;
  assign w_chg       = (w_nmode != r_mode);
  assign w_timed     = (w_nmode == RUN) || (w_nmode == FAST);
  assign w_div_m1    = (w_nmode == FAST) ? CW'(FAST_DIV - 1) : CW'(RUN_DIV - 1);
  // Entering EDIT starts the write tally from zero, even if a send lands on the entry edge
  assign w_lc_base   = (r_mode == EDIT) ? r_load_count : 8'd0;

  // Next-mode priority: edit, sticky halt, halt, speedRun, run, idle
  always_comb begin
    w_nmode = IDLE;
    if (i_edit)              w_nmode = EDIT;
    else if (r_mode == HALT) w_nmode = HALT;
    else if (i_halt)         w_nmode = HALT;
    else if (i_speedRun)     w_nmode = FAST;
    else if (i_run)          w_nmode = RUN;
  end

  // Mode register, prescaler, edge samples and all registered strobes
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mode       <= IDLE;
      r_cnt        <= '0;
      r_next_q     <= 1'b1;
      r_send_q     <= 1'b1;
      r_step_en    <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_pc_clear   <= 1'b0;
      r_rom_we     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_wdata  <= '0;
      r_load_count <= 8'd0;
    end else begin
      r_next_q   <= i_next;
      r_send_q   <= i_send;
      r_mode     <= w_nmode;
      r_step_en  <= 1'b0;
      r_rom_we   <= 1'b0;
      r_pc_clear <= 1'b0;
      r_cpu_hold <= (w_nmode == EDIT);

      // Prescaler restarts on any mode change; a wrap in RUN/FAST is a step
      if (w_chg || !w_timed) begin
        r_cnt <= '0;
      end else if (r_cnt == w_div_m1) begin
        r_cnt     <= '0;
        r_step_en <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Manual single step; not on the EDIT exit edge so it never meets pc_clear
      if (w_nmode == IDLE && r_mode != EDIT && w_next_rise)
        r_step_en <= 1'b1;

      // Programming: capture line/code on a send edge, count writes with saturation
      if (w_nmode == EDIT) begin
        r_load_count <= w_lc_base;
        if (w_send_rise) begin
          r_rom_we     <= 1'b1;
          r_rom_addr   <= i_line;
          r_rom_wdata  <= i_code;
          r_load_count <= (w_lc_base == 8'hFF) ? 8'hFF : w_lc_base + 8'd1;
        end
      end

      // Leaving EDIT restarts the CPU program counter
      if (r_mode == EDIT && w_nmode != EDIT)
        r_pc_clear <= 1'b1;
    end
  end

  assign o_step_en    = r_step_en;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_pc_clear   = r_pc_clear;
  assign o_rom_we     = r_rom_we;
  assign o_rom_addr   = r_rom_addr;
  assign o_rom_wdata  = r_rom_wdata;
  assign o_mode       = r_mode;
  assign o_load_count = r_load_count;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a ROM-write scoreboard.
module tb_exec_controller;

  localparam int ADDR_W = 8;
  localparam int CODE_W = 32;

  logic              clk = 1'b0;
  logic              rst, next, run, speedRun, edit, send, halt;
  logic [ADDR_W-1:0] line;
  logic [CODE_W-1:0] code;
  logic              step_en, cpu_hold, pc_clear, rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [CODE_W-1:0] rom_wdata;
  logic [2:0]        mode;
  logic [7:0]        load_count;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int we_cnt = 0;
  logic monitor_on = 1'b0;
  logic [ADDR_W+CODE_W-1:0] exp_q[$];

  exec_controller #(.RUN_DIV(4), .FAST_DIV(2), .ADDR_W(ADDR_W), .CODE_W(CODE_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_next(next), .i_run(run), .i_speedRun(speedRun),
    .i_edit(edit), .i_line(line), .i_code(code), .i_send(send), .i_halt(halt),
    .o_step_en(step_en), .o_cpu_hold(cpu_hold), .o_pc_clear(pc_clear),
    .o_rom_we(rom_we), .o_rom_addr(rom_addr), .o_rom_wdata(rom_wdata),
    .o_mode(mode), .o_load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [CODE_W-1:0] d);
    line = a;
    code = d;
    send = 1'b1;
    exp_q.push_back({a, d});
  endtask

  // Monitor: scoreboard pop on every rom_we, strobe exclusivity, step counting
  always @(negedge clk) begin
    if (monitor_on) begin
      if (step_en) step_cnt++;
      chk("strobe_exclusive", 64'(step_en + rom_we + pc_clear > 1), 64'd0);
      if (rom_we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rom_we", 64'd1, 64'd0);
        end else begin
          logic [ADDR_W+CODE_W-1:0] e;
          e = exp_q.pop_front();
          chk("rom_write", 64'({rom_addr, rom_wdata}), 64'(e));
        end
      end
    end
  end

  initial begin
    int s0, w0;
    rst = 1'b0; next = 1'b1; run = 1'b0; speedRun = 1'b0; edit = 1'b0;
    send = 1'b0; halt = 1'b0; line = '0; code = '0;

    // 1. reset state, next held high across reset, then a clean next edge
    tick(); tick();
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_outs", 64'({step_en, cpu_hold, pc_clear, rom_we}), 64'd0);
    chk("rst_addr_data", 64'({rom_addr, rom_wdata}), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    monitor_on = 1'b1;
    rst = 1'b1;
    tick(); chk("no_step_after_rst_a", 64'(step_en), 64'd0);
    tick(); chk("no_step_after_rst_b", 64'(step_en), 64'd0);
    next = 1'b0; tick();
    next = 1'b1; tick(); chk("idle_step_pulse", 64'(step_en), 64'd1);
    tick(); chk("idle_step_one_cycle", 64'(step_en), 64'd0);
    tick(); chk("idle_step_total", 64'(step_cnt), 64'd1);
    next = 1'b0;

    // 2. RUN: steps at 4,8,12 after entry; FAST: every 2 after switch
    run = 1'b1; tick();
    chk("run_mode", 64'(mode), 64'd1);
    for (int i = 1; i <= 12; i++) begin
      tick(); chk($sformatf("run_step_c%0d", i), 64'(step_en), 64'(i % 4 == 0));
    end
    speedRun = 1'b1; tick();
    chk("fast_mode", 64'(mode), 64'd2);
    chk("fast_switch_no_step", 64'(step_en), 64'd0);
    for (int i = 1; i <= 6; i++) begin
      tick(); chk($sformatf("fast_step_c%0d", i), 64'(step_en), 64'(i % 2 == 0));
    end

    // 3. EDIT programming of three lines, then exit
    run = 1'b0; speedRun = 1'b0; edit = 1'b1; tick();
    chk("edit_mode", 64'(mode), 64'd3);
    chk("edit_hold", 64'(cpu_hold), 64'd1);
    chk("edit_lc_clear", 64'(load_count), 64'd0);
    push_write(8'h00, 32'hDEADBEEF); tick(); send = 1'b0; tick();
    push_write(8'h01, 32'h12345678); tick(); send = 1'b0; tick();
    push_write(8'hFF, 32'h00000000); tick(); send = 1'b0; tick();
    chk("edit_load_count3", 64'(load_count), 64'd3);
    chk("edit_addr_hold", 64'(rom_addr), 64'hFF);
    s0 = step_cnt;
    edit = 1'b0; tick();
    chk("exit_pc_clear", 64'(pc_clear), 64'd1);
    chk("exit_hold_low", 64'(cpu_hold), 64'd0);
    chk("exit_mode_idle", 64'(mode), 64'd0);
    tick(); chk("pc_clear_one_cycle", 64'(pc_clear), 64'd0);
    chk("edit_no_steps", 64'(step_cnt), 64'(s0));

    // 4. halt coinciding with a RUN wrap, sticky HALT, leave through EDIT
    run = 1'b1; tick(); tick(); tick(); tick();
    s0 = step_cnt;
    halt = 1'b1; tick();
    chk("halt_mode", 64'(mode), 64'd4);
    chk("halt_wrap_suppressed", 64'(step_en), 64'd0);
    halt = 1'b0; speedRun = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next = ~next; tick();
    end
    chk("halt_sticky", 64'(mode), 64'd4);
    chk("halt_no_steps", 64'(step_cnt), 64'(s0));
    edit = 1'b1; next = 1'b0; tick();
    chk("halt_to_edit", 64'(mode), 64'd3);
    edit = 1'b0; run = 1'b0; speedRun = 1'b0; tick();
    chk("halt_exit_idle", 64'(mode), 64'd0);
    chk("halt_exit_pc_clear", 64'(pc_clear), 64'd1);

    // 5. 300 writes: load_count saturates, every write still strobes
    edit = 1'b1; tick();
    w0 = we_cnt;
    for (int i = 0; i < 300; i++) begin
      push_write(8'(i), 32'(i * 32'h01010101 + 7)); tick();
      send = 1'b0; tick();
      if (i == 253) chk("lc_254", 64'(load_count), 64'd254);
    end
    chk("lc_saturated", 64'(load_count), 64'd255);
    chk("we_300", 64'(we_cnt - w0), 64'd300);

    // 6. reset on the edge that samples a send rise: write dropped
    line = 8'h55; code = 32'hA5A5A5A5; send = 1'b1; rst = 1'b0; tick();
    chk("rst_we_dropped", 64'(rom_we), 64'd0);
    chk("rst2_mode", 64'(mode), 64'd0);
    chk("rst2_outs", 64'({step_en, cpu_hold, pc_clear, rom_we}), 64'd0);
    chk("rst2_addr_data", 64'({rom_addr, rom_wdata}), 64'd0);
    chk("rst2_load_count", 64'(load_count), 64'd0);
    tick(); rst = 1'b1; tick(); tick();
    chk("rst2_send_held_no_we", 64'(rom_we), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    monitor_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
